// File: rtl/shift_pkg.sv
// Shared definitions for the shift_reg datapath and its command sequencer:
// control codes, sequencer states and the op legality check.
package shift_pkg;

  localparam logic [2:0] SR_CLR    = 3'b000;
  localparam logic [2:0] SR_LOAD   = 3'b001;
  localparam logic [2:0] SR_ROR    = 3'b010;
  localparam logic [2:0] SR_ROL    = 3'b011;
  localparam logic [2:0] SR_ASR    = 3'b100;
  localparam logic [2:0] SR_LFSR_R = 3'b110;
  localparam logic [2:0] SR_LFSR_L = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_t;

  // 101 has no datapath meaning; 111 exists in shift_reg but the sequencer refuses it.
  function automatic logic op_legal(input logic [2:0] op);
    case (op)
      SR_CLR, SR_LOAD, SR_ROR, SR_ROL, SR_ASR, SR_LFSR_R: op_legal = 1'b1;
      default:                                            op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shift_reg.sv
// Shift register datapath driven by a 3-bit control code every clock.
// No reset and no hold code: the owner clears it with SR_CLR and holds it by reloading dout.
module shift_reg
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic [2:0]       ctl,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic signed [WIDTH-1:0] dout_s;

  assign dout_s = dout;

  // Feedback taps 4,3,2,0 shared by both LFSR directions.
  function automatic logic lfsr_fb(input logic [WIDTH-1:0] v);
    return v[4] ^ v[3] ^ v[2] ^ v[0];
  endfunction

  always_ff @(posedge clk) begin
    case (ctl)
      SR_CLR:    dout <= '0;
      SR_LOAD:   dout <= din;
      SR_ROR:    dout <= {dout[0], dout[WIDTH-1:1]};
      SR_ROL:    dout <= {dout[WIDTH-2:0], dout[WIDTH-1]};
      SR_ASR:    dout <= dout_s >>> 1;
      SR_LFSR_R: dout <= {lfsr_fb(dout), dout[WIDTH-1:1]};
      SR_LFSR_L: dout <= {dout[WIDTH-2:0], lfsr_fb(dout)};
      default:   dout <= dout;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Command sequencer for shift_reg: accepts (op, data, cnt), loads once, shifts cnt times,
// then presents the final register value until the consumer takes it.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err,
  output logic [2:0]       sr_ctl,
  output logic [WIDTH-1:0] sr_din,
  input  logic [WIDTH-1:0] sr_dout
);

  state_t           state_q, state_d;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] data_q;
  logic [CNT_W-1:0] rem_q;
  logic             err_q;
  logic             cmd_acc;
  logic             res_acc;

  assign cmd_acc = cmd_valid && cmd_ready;
  assign res_acc = res_valid && res_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (cmd_acc) state_d = op_legal(cmd_op) ? ST_LOAD : ST_DONE;
      ST_LOAD:  state_d = (op_q == SR_LOAD || rem_q == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (rem_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  if (res_acc) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // A clear command always shifts exactly once, so its count is forced to 1 at accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (cmd_acc) begin
        rem_q <= (cmd_op == SR_CLR) ? CNT_W'(1) : cmd_cnt;
        err_q <= !op_legal(cmd_op);
      end else if (state_q == ST_SHIFT) begin
        rem_q <= rem_q - CNT_W'(1);
      end
      if (res_acc) err_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (cmd_acc) begin
      op_q   <= cmd_op;
      data_q <= cmd_data;
    end
  end

  // Outside LOAD/SHIFT the register is held by reloading its own output.
  always_comb begin
    cmd_ready = 1'b0;
    res_valid = 1'b0;
    res_err   = 1'b0;
    res_data  = sr_dout;
    sr_ctl    = SR_LOAD;
    sr_din    = sr_dout;
    if (rst) begin
      sr_ctl = SR_CLR;
    end else begin
      case (state_q)
        ST_IDLE:  cmd_ready = 1'b1;
        ST_LOAD:  sr_din = data_q;
        ST_SHIFT: sr_ctl = op_q;
        ST_DONE: begin
          res_valid = 1'b1;
          res_err   = err_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_seq_ctrl.sv
// Bench for shift_seq_ctrl wired to shift_reg: directed cases plus random commands
// compared with an arithmetic model of the register value, error flag and latency.
module tb_shift_seq_ctrl;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_cnt;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_err;
  logic [2:0]       sr_ctl;
  logic [WIDTH-1:0] sr_din;
  logic [WIDTH-1:0] sr_dout;

  int checks = 0;
  int errors = 0;
  logic [7:0] reg_m;

  always #5 clk = ~clk;

  shift_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err),
    .sr_ctl(sr_ctl), .sr_din(sr_din), .sr_dout(sr_dout)
  );

  shift_reg #(.WIDTH(WIDTH)) u_sr (
    .clk(clk), .ctl(sr_ctl), .din(sr_din), .dout(sr_dout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int step(input int op, input int v);
    int fb;
    fb = ((v >> 4) ^ (v >> 3) ^ (v >> 2) ^ v) & 1;
    case (op)
      2:       return ((v >> 1) | (v << 7)) & 255;
      3:       return ((v << 1) | (v >> 7)) & 255;
      4:       return (v >> 1) | (v & 128);
      6:       return (fb << 7) | (v >> 1);
      default: return v;
    endcase
  endfunction

  // Expected result, error flag and cycles from accept to visible res_valid.
  task automatic model(input int op, input int data, input int cnt,
                       output logic [7:0] d, output logic e, output int lat);
    int v;
    e = 1'b0;
    if (op == 5 || op == 7) begin
      d = reg_m; e = 1'b1; lat = 1;
    end else if (op == 1) begin
      d = 8'(data); lat = 2;
    end else if (op == 0) begin
      d = 8'h00; lat = 3;
    end else if (cnt == 0) begin
      d = 8'(data); lat = 2;
    end else begin
      v = data;
      for (int i = 0; i < cnt; i++) v = step(op, v);
      d = 8'(v); lat = 2 + cnt;
    end
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [7:0] data,
                         input logic [3:0] cnt, input int stall);
    logic [7:0] exp_d;
    logic       exp_e;
    int         exp_lat;
    int         lat;
    model(int'(op), int'(data), int'(cnt), exp_d, exp_e, exp_lat);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_data = data; cmd_cnt = cnt; res_ready = 1'b0;
    lat = 0;
    while (!cmd_ready && lat < 50) begin @(negedge clk); lat++; end
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!res_valid) begin
        chk({tag, "_busy_ready"}, 32'(cmd_ready), 32'd0);
        cmd_op = 3'($urandom); cmd_data = 8'($urandom); cmd_cnt = 4'($urandom);
      end
    end while (!res_valid && lat < 40);
    cmd_valid = 1'b0;
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd1);
    chk({tag, "_res_data"}, 32'(res_data), 32'(exp_d));
    chk({tag, "_res_err"}, 32'(res_err), 32'(exp_e));
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk({tag, "_stall_valid"}, 32'(res_valid), 32'd1);
      chk({tag, "_stall_data"}, 32'(res_data), 32'(exp_d));
      chk({tag, "_stall_ctl"}, 32'(sr_ctl), 32'd1);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    chk({tag, "_post_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_post_ready"}, 32'(cmd_ready), 32'd1);
    reg_m = exp_d;
  endtask

  initial begin
    int n;
    logic [2:0] rop;
    rst = 1'b1; cmd_valid = 1'b0; res_ready = 1'b0;
    cmd_op = 3'd0; cmd_data = 8'd0; cmd_cnt = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_res_err", 32'(res_err), 32'd0);
    chk("rst_sr_ctl", 32'(sr_ctl), 32'd0);
    chk("rst_sr_dout", 32'(sr_dout), 32'd0);
    rst = 1'b0;
    #1;
    chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rel_sr_ctl", 32'(sr_ctl), 32'd1);
    reg_m = 8'h00;

    run_cmd("ror", 3'b010, 8'h81, 4'd1, 0);
    run_cmd("rol_stall", 3'b011, 8'h81, 4'd3, 5);
    run_cmd("asr", 3'b100, 8'h80, 4'd2, 0);
    run_cmd("lfsr_r", 3'b110, 8'h01, 4'd1, 0);
    run_cmd("cnt0", 3'b010, 8'h5A, 4'd0, 0);
    run_cmd("clr", 3'b000, 8'hA5, 4'd9, 1);
    run_cmd("load3c", 3'b001, 8'h3C, 4'd4, 0);
    run_cmd("illegal101", 3'b101, 8'hFF, 4'd2, 2);
    run_cmd("after_err", 3'b011, 8'h11, 4'd2, 0);
    run_cmd("illegal111", 3'b111, 8'h00, 4'd0, 0);
    run_cmd("max_cnt", 3'b010, 8'h81, 4'd15, 0);

    // Reset during the fourth SHIFT cycle of a long rotate.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_data = 8'hC3; cmd_cnt = 4'd15;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_sr_ctl", 32'(sr_ctl), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("midrst_res_valid", 32'(res_valid), 32'd0);
    @(negedge clk);
    chk("midrst_sr_dout", 32'(sr_dout), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_rel_ready", 32'(cmd_ready), 32'd1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (res_valid) n++;
    end
    chk("midrst_no_result", 32'(n), 32'd0);
    chk("midrst_hold_zero", 32'(sr_dout), 32'd0);
    reg_m = 8'h00;

    // Two queued commands with the consumer always ready.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 3'b010; cmd_data = 8'h81; cmd_cnt = 4'd1; res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_op = 3'b011; cmd_data = 8'h81; cmd_cnt = 4'd2;
    n = 0;
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    chk("b2b_first_data", 32'(res_data), 32'h0C0);
    @(negedge clk);
    chk("b2b_ready_after_hs", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("b2b_second_taken", 32'(cmd_ready), 32'd0);
    n = 0;
    while (!res_valid && n < 40) begin @(negedge clk); n++; end
    chk("b2b_second_lat", 32'(n + 1), 32'd4);
    chk("b2b_second_data", 32'(res_data), 32'h006);
    @(negedge clk);
    res_ready = 1'b0;
    reg_m = 8'h06;

    for (int k = 0; k < 25; k++) begin
      rop = 3'($urandom_range(0, 7));
      run_cmd("rand", rop, 8'($urandom), 4'($urandom), int'($urandom_range(0, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
